trng_frame_scheduler: RTL and testbench
=======================================

Name: trng_frame_scheduler

Overview:
Single-clock controller that sequences readout of one completed TRNG batch from the collector's read port into the UART transmitter. Each batch is wrapped in a fixed frame: sync bytes, sequence number, length, payload and XOR checksum. When the frame is fully sent, the block re-arms the collector. It sits in the 100 MHz domain between the collector read port and uart_tx_core, replacing the ad-hoc transmit FSM in the top level.

Parameters:
BATCH_SIZE, 1000, payload bytes per frame (1..65535)
ADDR_W, 32, collector read-address width
SYNC0, 8'hA5, first sync byte
SYNC1, 8'h5A, second sync byte

Ports:
iClk  in  1  system clock (100 MHz)
iRst  in  1  synchronous, active-high reset
iEnable  in  1  allows new frames to start
iBatchDone  in  1  collector done level, already synchronous to iClk
oMemRdEn  out  1  collector read enable
oMemRdAddr  out  ADDR_W  collector read address
iMemRdData  in  8  collector read data, valid 1 cycle after oMemRdEn
oTxStart  out  1  one-cycle start pulse to UART
oTxData  out  8  byte to UART, held until next oTxStart
iTxBusy  in  1  UART busy
oRearm  out  1  one-cycle pulse: collector may start next batch
oActive  out  1  high whenever state != IDLE
oBatchSeq  out  8  sequence number of next frame
oFramesSent  out  16  completed-frame counter
oOverrun  out  1  sticky: batch edge arrived while busy

Behaviour:
- Clock and reset: one clock (iClk); reset iRst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; byte index 0; checksum 0; previous-done register 0.
- Reset mid-frame: the block returns to IDLE on the next edge and the frame is abandoned. The sequence number also resets.
- Edge detect: edge = iBatchDone & ~done_q, where done_q is the registered iBatchDone.
- Frame layout: SYNC0, SYNC1, SEQ, LEN[15:8], LEN[7:0], payload[0..BATCH_SIZE-1], CHK.
  - LEN = BATCH_SIZE[15:0].
  - CHK = XOR of the payload bytes only.
- States:
  - IDLE: on edge with iEnable=1, clear the index and checksum and go to HDR. If edge occurs with iEnable=0, ignore it.
  - HDR: when iTxBusy=0, register oTxData = header byte[idx], pulse oTxStart, go to WAIT_TX.
  - RD_REQ: register oMemRdEn=1 (one cycle) and oMemRdAddr = payload index; go to RD_WAIT.
  - RD_WAIT: one cycle for read latency; go to SEND.
  - SEND: when iTxBusy=0, capture iMemRdData into oTxData, pulse oTxStart, XOR the byte into the checksum, go to WAIT_TX.
  - WAIT_TX: ignore iTxBusy in the first cycle (start-to-busy guard). Afterwards, when iTxBusy=0, advance the byte counter and go to:
    - HDR if the header is incomplete,
    - RD_REQ if payload remains,
    - CHK after the last payload byte,
    - REARM after CHK was sent.
  - CHK: when iTxBusy=0, send the checksum byte and go to WAIT_TX.
  - REARM: pulse oRearm; oBatchSeq+1 (wraps 255->0); oFramesSent+1 (wraps 65535->0); go to IDLE.
- Start latency: edge sampled in cycle N, HDR entered at N+1, first oTxStart visible at N+2 with oTxData=SYNC0 (when iTxBusy=0).
- Guard rule: no oTxStart is issued while iTxBusy=1. This covers a UART still busy after a reset.
- iEnable falling mid-frame: the frame completes normally; only new starts are gated.
- Edge while state != IDLE: set oOverrun (sticky until iRst) and drop the edge.
- oMemRdAddr holds its value between reads.
- oTxStart is never high on two consecutive cycles.

Decomposition:
- Shared package trng_pkg holds:
  - the state enum (IDLE, HDR, RD_REQ, RD_WAIT, SEND, WAIT_TX, CHK, REARM),
  - HDR_LEN=5,
  - default SYNC0/SYNC1 constants.
- One natural sub-module: edge_detect (registered rising-edge pulse), reusable by the top level.

Test Plan (bench BATCH_SIZE=4; UART model asserts busy from 1 cycle after start for 20 cycles):
- Memory {11,22,33,44}, iEnable=1, iBatchDone rises -> UART bytes A5 5A 00 00 04 11 22 33 44 44; oRearm single pulse; oFramesSent=1; oBatchSeq=1.
- Second batch after oRearm -> SEQ byte 01; oFramesSent=2.
- iBatchDone re-rises during payload -> oOverrun=1; frame unaffected; no second frame.
- iEnable=0 at edge -> no oTxStart, oActive stays 0. iEnable dropped mid-frame -> all 10 bytes still sent.
- iRst asserted during payload byte 2 -> next cycle all outputs 0, state IDLE. Next edge produces a full frame with SEQ 00. Hold iTxBusy=1 after reset -> first oTxStart waits until iTxBusy=0.
- Check every oMemRdEn: address sequence 0,1,2,3; iMemRdData sampled exactly 2 cycles after oMemRdEn rises; oTxStart never high while busy.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared constants, FSM state encodings and header-byte helper for the TRNG frame scheduler.
package trng_pkg;

  localparam int unsigned HDR_LEN = 5;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StHdr    = 3'd1;
  localparam logic [2:0] StRdReq  = 3'd2;
  localparam logic [2:0] StRdWait = 3'd3;
  localparam logic [2:0] StSend   = 3'd4;
  localparam logic [2:0] StWaitTx = 3'd5;
  localparam logic [2:0] StChk    = 3'd6;
  localparam logic [2:0] StRearm  = 3'd7;

  // Header layout: SYNC0, SYNC1, SEQ, LEN[15:8], LEN[7:0]
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  sync0,
                                          input logic [7:0]  sync1,
                                          input logic [7:0]  seq,
                                          input logic [15:0] len);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync0;
      3'd1:    b = sync1;
      3'd2:    b = seq;
      3'd3:    b = len[15:8];
      default: b = len[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trng_frame_scheduler_if.sv
// Collector read port and UART transmit handshake seen by the frame scheduler.
interface trng_frame_scheduler_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              oMemRdEn;
  logic [ADDR_W-1:0] oMemRdAddr;
  logic [7:0]        iMemRdData;
  logic              oTxStart;
  logic [7:0]        oTxData;
  logic              iTxBusy;

  modport master (
    output oMemRdEn, oMemRdAddr, oTxStart, oTxData,
    input  iMemRdData, iTxBusy
  );

  modport slave (
    input  oMemRdEn, oMemRdAddr, oTxStart, oTxData,
    output iMemRdData, iTxBusy
  );
endinterface

// File: rtl/trng_frame_scheduler_edge_detect.sv
// Rising-edge detector on a level already synchronous to iClk.
module trng_frame_scheduler_edge_detect (
  input  logic iClk,
  input  logic iRst,
  input  logic iLevel,
  output logic oEdge
);

  logic level_q;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= iLevel;
    end
  end

  assign oEdge = iLevel & ~level_q;

endmodule

// File: rtl/trng_frame_scheduler.sv
// Frames one completed TRNG batch (sync, seq, len, payload, XOR checksum) out to the UART,
// then re-arms the collector.
module trng_frame_scheduler
  import trng_pkg::*;
#(
  parameter int unsigned BATCH_SIZE = 1000,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [7:0]  SYNC0      = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1      = SYNC1_DEFAULT
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iEnable,
  input  logic                          iBatchDone,
  trng_frame_scheduler_if.master        bus,
  output logic                          oRearm,
  output logic                          oActive,
  output logic [7:0]                    oBatchSeq,
  output logic [15:0]                   oFramesSent,
  output logic                          oOverrun
);

  localparam logic [15:0] LEN     = 16'(BATCH_SIZE);
  localparam logic [16:0] HDR_END = 17'(HDR_LEN);
  // Frame index of the checksum byte
  localparam logic [16:0] PAY_END = 17'(HDR_LEN + BATCH_SIZE);

  logic [2:0]  state_q;
  logic [16:0] byte_idx_q;
  logic [7:0]  chk_q;
  logic        guard_q;
  logic        batch_edge;

  logic [16:0] next_idx;
  logic [2:0]  wait_next;
  logic [16:0] payload_addr;

  trng_frame_scheduler_edge_detect u_edge (
    .iClk   (iClk),
    .iRst   (iRst),
    .iLevel (iBatchDone),
    .oEdge  (batch_edge)
  );

  always_comb begin
    next_idx     = byte_idx_q + 17'd1;
    payload_addr = byte_idx_q - HDR_END;
    if (next_idx < HDR_END) begin
      wait_next = StHdr;
    end else if (next_idx < PAY_END) begin
      wait_next = StRdReq;
    end else if (next_idx == PAY_END) begin
      wait_next = StChk;
    end else begin
      wait_next = StRearm;
    end
  end

  assign oActive = (state_q != StIdle);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q        <= StIdle;
      byte_idx_q     <= '0;
      chk_q          <= '0;
      guard_q        <= 1'b0;
      bus.oTxStart   <= 1'b0;
      bus.oTxData    <= '0;
      bus.oMemRdEn   <= 1'b0;
      bus.oMemRdAddr <= '0;
      oRearm         <= 1'b0;
      oBatchSeq      <= '0;
      oFramesSent    <= '0;
      oOverrun       <= 1'b0;
    end else begin
      bus.oTxStart <= 1'b0;
      bus.oMemRdEn <= 1'b0;
      oRearm       <= 1'b0;

      if (batch_edge && (state_q != StIdle)) begin
        oOverrun <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (batch_edge && iEnable) begin
            byte_idx_q <= '0;
            chk_q      <= '0;
            state_q    <= StHdr;
          end
        end
        StHdr: begin
          if (!bus.iTxBusy) begin
            bus.oTxData  <= hdr_byte(byte_idx_q[2:0], SYNC0, SYNC1, oBatchSeq, LEN);
            bus.oTxStart <= 1'b1;
            guard_q      <= 1'b1;
            state_q      <= StWaitTx;
          end
        end
        StRdReq: begin
          bus.oMemRdEn   <= 1'b1;
          bus.oMemRdAddr <= ADDR_W'(payload_addr);
          state_q        <= StRdWait;
        end
        StRdWait: begin
          state_q <= StSend;
        end
        StSend: begin
          if (!bus.iTxBusy) begin
            bus.oTxData  <= bus.iMemRdData;
            bus.oTxStart <= 1'b1;
            chk_q        <= chk_q ^ bus.iMemRdData;
            guard_q      <= 1'b1;
            state_q      <= StWaitTx;
          end
        end
        StWaitTx: begin
          // UART raises busy a cycle after start, so the first cycle here is blind
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (!bus.iTxBusy) begin
            byte_idx_q <= next_idx;
            state_q    <= wait_next;
          end
        end
        StChk: begin
          if (!bus.iTxBusy) begin
            bus.oTxData  <= chk_q;
            bus.oTxStart <= 1'b1;
            guard_q      <= 1'b1;
            state_q      <= StWaitTx;
          end
        end
        StRearm: begin
          oRearm      <= 1'b1;
          oBatchSeq   <= oBatchSeq + 8'd1;
          oFramesSent <= oFramesSent + 16'd1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_frame_scheduler.sv
// Randomized bench for trng_frame_scheduler against a frame-level reference model.
module tb_trng_frame_scheduler;
  import trng_pkg::*;

  localparam int unsigned BATCH    = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int          BUSY_CYC = 20;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iEnable;
  logic        iBatchDone;
  logic        oRearm;
  logic        oActive;
  logic [7:0]  oBatchSeq;
  logic [15:0] oFramesSent;
  logic        oOverrun;

  trng_frame_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  trng_frame_scheduler #(
    .BATCH_SIZE (BATCH),
    .ADDR_W     (ADDR_W),
    .SYNC0      (8'hA5),
    .SYNC1      (8'h5A)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iEnable     (iEnable),
    .iBatchDone  (iBatchDone),
    .bus         (bus),
    .oRearm      (oRearm),
    .oActive     (oActive),
    .oBatchSeq   (oBatchSeq),
    .oFramesSent (oFramesSent),
    .oOverrun    (oOverrun)
  );

  always #5 iClk = ~iClk;

  // Collector read port: one-cycle read latency
  logic [7:0] mem [BATCH];
  always @(posedge iClk) begin
    if (bus.oMemRdEn) bus.iMemRdData <= mem[bus.oMemRdAddr[1:0]];
  end

  // UART: busy from one cycle after start for BUSY_CYC cycles
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  always @(posedge iClk) begin
    if (bus.oTxStart) busy_cnt <= BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.iTxBusy = (busy_cnt != 0) || force_busy;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor
  logic [7:0] tx_q[$];
  int   cyc = 0, rden_cyc = -100, frame_pos = 0, rd_idx = 0, rearm_cnt = 0, start_cnt = 0;
  logic prev_start = 1'b0, prev_rearm = 1'b0;

  always @(negedge iClk) begin
    cyc++;
    if (!oActive) begin
      frame_pos = 0;
      rd_idx    = 0;
    end
    if (bus.oMemRdEn) begin
      check("rd_addr", bus.oMemRdAddr, rd_idx);
      rd_idx++;
      rden_cyc = cyc;
    end
    if (bus.oTxStart) begin
      check("start_while_busy", {31'd0, bus.iTxBusy}, 0);
      check("start_back_to_back", {31'd0, prev_start}, 0);
      if (frame_pos >= 5 && frame_pos < 5 + BATCH) check("rd_latency", cyc - rden_cyc, 2);
      tx_q.push_back(bus.oTxData);
      frame_pos++;
      start_cnt++;
    end
    if (oRearm) begin
      check("rearm_back_to_back", {31'd0, prev_rearm}, 0);
      rearm_cnt++;
    end
    prev_start = bus.oTxStart;
    prev_rearm = oRearm;
  end

  // Reference model
  int         model_seq    = 0;
  int         model_frames = 0;
  logic [7:0] exp_q[$];

  task automatic build_exp(input int seq);
    logic [7:0] x;
    logic [15:0] len;
    len = 16'(BATCH);
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(seq % 256));
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    for (int i = 0; i < BATCH; i++) begin
      exp_q.push_back(mem[i]);
      x = x ^ mem[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, tx_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic wait_rearm(input int r0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick(1);
      if (rearm_cnt != r0) ok = 1'b1;
    end
  endtask

  task automatic wait_rd(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick(1);
      if (rd_idx >= n) ok = 1'b1;
    end
  endtask

  task automatic finish_frame(input string tag, input int r0);
    bit ok;
    wait_rearm(r0, ok);
    check({tag, "_rearm_seen"}, {31'd0, ok}, 1);
    model_seq++;
    model_frames++;
    tick(3);
    check({tag, "_rearm_pulses"}, rearm_cnt - r0, 1);
    check({tag, "_seq"}, oBatchSeq, model_seq % 256);
    check({tag, "_frames"}, oFramesSent, model_frames % 65536);
    check({tag, "_idle"}, {31'd0, oActive}, 0);
    compare_frame(tag);
  endtask

  task automatic run_frame(input string tag, input bit drop_en);
    int r0;
    for (int i = 0; i < BATCH; i++) mem[i] = 8'($urandom);
    tx_q.delete();
    build_exp(model_seq);
    r0 = rearm_cnt;
    tick($urandom_range(1, 8));
    iBatchDone = 1'b1;
    tick(3);
    iBatchDone = 1'b0;
    if (drop_en) iEnable = 1'b0;
    finish_frame(tag, r0);
  endtask

  initial begin
    bit ok;
    int r0, s0;
    bit act_seen;
    iRst       = 1'b1;
    iEnable    = 1'b0;
    iBatchDone = 1'b0;
    tick(3);
    check("rst_active", {31'd0, oActive}, 0);
    check("rst_txstart", {31'd0, bus.oTxStart}, 0);
    check("rst_rden", {31'd0, bus.oMemRdEn}, 0);
    check("rst_seq", oBatchSeq, 0);
    check("rst_frames", oFramesSent, 0);
    check("rst_overrun", {31'd0, oOverrun}, 0);
    iRst = 1'b0;
    tick(2);

    // Known payload plus start latency
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    iEnable = 1'b1;
    tx_q.delete();
    build_exp(model_seq);
    r0 = rearm_cnt;
    iBatchDone = 1'b1;
    tick(1);
    check("lat_active_n1", {31'd0, oActive}, 1);
    check("lat_nostart_n1", {31'd0, bus.oTxStart}, 0);
    tick(1);
    check("lat_start_n2", {31'd0, bus.oTxStart}, 1);
    check("lat_sync0_n2", {24'd0, bus.oTxData}, 32'hA5);
    tick(1);
    iBatchDone = 1'b0;
    finish_frame("f1", r0);
    check("f1_chk_const", {24'd0, tx_q.size() == 10 ? tx_q[9] : 8'h00}, 32'h44);

    run_frame("f2", 1'b0);

    // Overrun: edge during payload is dropped
    for (int i = 0; i < BATCH; i++) mem[i] = 8'($urandom);
    tx_q.delete();
    build_exp(model_seq);
    r0 = rearm_cnt;
    iBatchDone = 1'b1;
    tick(3);
    iBatchDone = 1'b0;
    wait_rd(2, ok);
    check("ovr_rd_seen", {31'd0, ok}, 1);
    iBatchDone = 1'b1;
    tick(1);
    check("ovr_flag", {31'd0, oOverrun}, 1);
    finish_frame("ovr", r0);
    s0 = start_cnt;
    tick(200);
    check("ovr_no_second", start_cnt - s0, 0);
    check("ovr_sticky", {31'd0, oOverrun}, 1);
    iBatchDone = 1'b0;
    tick(2);

    // Disabled at edge
    iEnable = 1'b0;
    s0 = start_cnt;
    act_seen = 1'b0;
    iBatchDone = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i == 3) iBatchDone = 1'b0;
      if (oActive) act_seen = 1'b1;
    end
    check("dis_active", {31'd0, act_seen}, 0);
    check("dis_starts", start_cnt - s0, 0);
    iEnable = 1'b1;
    run_frame("drop_en", 1'b1);
    iEnable = 1'b1;

    // Reset mid-payload with UART held busy afterwards
    for (int i = 0; i < BATCH; i++) mem[i] = 8'($urandom);
    iBatchDone = 1'b1;
    tick(3);
    iBatchDone = 1'b0;
    wait_rd(3, ok);
    check("rst_mid_rd_seen", {31'd0, ok}, 1);
    iRst = 1'b1;
    force_busy = 1'b1;
    tick(1);
    check("mid_rst_active", {31'd0, oActive}, 0);
    check("mid_rst_txstart", {31'd0, bus.oTxStart}, 0);
    check("mid_rst_txdata", {24'd0, bus.oTxData}, 0);
    check("mid_rst_rden", {31'd0, bus.oMemRdEn}, 0);
    check("mid_rst_rdaddr", bus.oMemRdAddr, 0);
    check("mid_rst_rearm", {31'd0, oRearm}, 0);
    check("mid_rst_seq", oBatchSeq, 0);
    check("mid_rst_frames", oFramesSent, 0);
    check("mid_rst_overrun", {31'd0, oOverrun}, 0);
    iRst = 1'b0;
    model_seq = 0;
    model_frames = 0;
    tick(2);
    tx_q.delete();
    build_exp(model_seq);
    r0 = rearm_cnt;
    s0 = start_cnt;
    iBatchDone = 1'b1;
    tick(3);
    iBatchDone = 1'b0;
    tick(30);
    check("busy_hold_starts", start_cnt - s0, 0);
    check("busy_hold_active", {31'd0, oActive}, 1);
    force_busy = 1'b0;
    finish_frame("post_rst", r0);

    for (int k = 0; k < 3; k++) run_frame($sformatf("rnd%0d", k), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
